// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   ps2_state_e   deframer state encoding (idle, data bits, parity bit, stop bit)
//   PS2_EXT       extended-code prefix byte
//   PS2_BRK       break (key release) prefix byte
//   PS2_SPACE     space-bar scan code, the default jump key
//   odd_parity_ok returns 1 when data bits plus parity bit hold an odd number of ones
package ps2_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StStop
   } ps2_state_e;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_SPACE = 8'h29;

   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_key_receiver_if.sv
// ps2_key_receiver_if: key-event bundle from the PS/2 receiver to the control unit.
//   scan_code    last decoded non-prefix scan code
//   code_valid   one-cycle strobe: scan_code / is_break / is_extended are valid
//   is_break     code was preceded by F0
//   is_extended  code was preceded by E0
//   frame_err    one-cycle strobe: parity error, bad stop bit or timeout
//   key_down     level: jump key currently held
//   jump_pulse   one-cycle strobe on key_down rising
// master = receiver (drives), slave = consumer.
interface ps2_key_receiver_if;
   import ps2_pkg::*;

   logic [7:0] scan_code;
   logic       code_valid;
   logic       is_break;
   logic       is_extended;
   logic       frame_err;
   logic       key_down;
   logic       jump_pulse;

   modport master (
      output scan_code, code_valid, is_break, is_extended, frame_err, key_down, jump_pulse
   );

   modport slave (
      input scan_code, code_valid, is_break, is_extended, frame_err, key_down, jump_pulse
   );

endinterface

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: brings the raw PS/2 lines into the clk domain.
//   clk          system clock
//   rst          asynchronous active-low reset
//   kb_clk_raw   raw PS/2 clock line
//   kb_data_raw  raw PS/2 data line
//   fall         one-cycle strobe on a 1->0 transition of the filtered PS/2 clock
//   data         synchronized PS/2 data, valid to sample while fall is high
module ps2_sync_filter
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic kb_clk_raw,
   input  logic kb_data_raw,
   output logic fall,
   output logic data
);

   localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

   logic [1:0]      clk_sync_q, data_sync_q;
   logic [CntW-1:0] filt_cnt_q, filt_cnt_d;
   logic            filt_q, filt_d;
   logic            filt_prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         filt_cnt_q  <= '0;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], kb_clk_raw};
         data_sync_q <= {data_sync_q[0], kb_data_raw};
         filt_cnt_q  <= filt_cnt_d;
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
      end
   end

   // Count consecutive samples that disagree with the filtered level; any agreeing
   // sample restarts the count, so pulses shorter than FILTER_LEN never get through.
   always_comb begin
      filt_cnt_d = '0;
      filt_d     = filt_q;
      if (clk_sync_q[1] != filt_q) begin
         if (filt_cnt_q == CntW'(FILTER_LEN - 1)) begin
            filt_d = clk_sync_q[1];
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   assign fall = filt_prev_q & ~filt_q;
   assign data = data_sync_q[1];

endmodule

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 keyboard front end for the game control unit.
//   clk      system clock, all logic on posedge
//   rst      asynchronous active-low reset
//   KBclk    raw PS/2 clock
//   KBin     raw PS/2 data
//   key_if   key-event outputs (scan code strobe, prefix flags, frame error,
//            jump-key level and pulse)
// Deframes 11-bit frames (start, 8 data LSB first, odd parity, stop), folds E0/F0
// prefixes into flags on the following code, and tracks the jump key.
module ps2_key_receiver
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter logic [7:0]  JUMP_CODE      = PS2_SPACE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 KBclk,
   input  logic                 KBin,
   ps2_key_receiver_if.master   key_if
);

   localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

   logic fall, data;

   ps2_sync_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_sync_filter (
      .clk         (clk),
      .rst         (rst),
      .kb_clk_raw  (KBclk),
      .kb_data_raw (KBin),
      .fall        (fall),
      .data        (data)
   );

   // Deframer state
   ps2_state_e     state_q, state_d;
   logic [2:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]     shift_q, shift_d;
   logic           par_q, par_d;
   logic [ToW-1:0] to_cnt_q, to_cnt_d;
   logic           byte_vld_q, byte_vld_d;
   logic [7:0]     byte_q, byte_d;
   logic           err_q, err_d;
   logic           to_abort;

   // Decoder and jump-key state
   logic       ext_q, ext_d, brk_q, brk_d;
   logic       cv_q, cv_d;
   logic [7:0] sc_q, sc_d;
   logic       ib_q, ib_d, ie_q, ie_d;
   logic       kd_q, kd_d, jp_q, jp_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         to_cnt_q   <= '0;
         byte_vld_q <= 1'b0;
         byte_q     <= '0;
         err_q      <= 1'b0;
         ext_q      <= 1'b0;
         brk_q      <= 1'b0;
         cv_q       <= 1'b0;
         sc_q       <= '0;
         ib_q       <= 1'b0;
         ie_q       <= 1'b0;
         kd_q       <= 1'b0;
         jp_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         to_cnt_q   <= to_cnt_d;
         byte_vld_q <= byte_vld_d;
         byte_q     <= byte_d;
         err_q      <= err_d;
         ext_q      <= ext_d;
         brk_q      <= brk_d;
         cv_q       <= cv_d;
         sc_q       <= sc_d;
         ib_q       <= ib_d;
         ie_q       <= ie_d;
         kd_q       <= kd_d;
         jp_q       <= jp_d;
      end
   end

   // Deframer FSM and mid-frame timeout. A fall always clears the timeout counter,
   // so a timeout can only be taken in a cycle without a fall.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      to_cnt_d   = to_cnt_q;
      byte_vld_d = 1'b0;
      byte_d     = byte_q;
      err_d      = 1'b0;
      to_abort   = 1'b0;
      if (fall) begin
         to_cnt_d = '0;
         unique case (state_q)
            StIdle: begin
               if (!data) begin
                  state_d   = StData;
                  bit_cnt_d = '0;
               end
            end
            StData: begin
               shift_d   = {data, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = StParity;
               end
            end
            StParity: begin
               par_d   = data;
               state_d = StStop;
            end
            StStop: begin
               state_d = StIdle;
               if (data && odd_parity_ok(shift_q, par_q)) begin
                  byte_vld_d = 1'b1;
                  byte_d     = shift_q;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end else if (state_q != StIdle) begin
         if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
            state_d  = StIdle;
            to_cnt_d = '0;
            err_d    = 1'b1;
            to_abort = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
   end

   // Prefix decoder: E0/F0 only arm flags; any other byte emits one code strobe.
   always_comb begin
      ext_d = ext_q;
      brk_d = brk_q;
      cv_d  = 1'b0;
      sc_d  = sc_q;
      ib_d  = ib_q;
      ie_d  = ie_q;
      if (to_abort) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (byte_vld_q) begin
         if (byte_q == PS2_EXT) begin
            ext_d = 1'b1;
         end else if (byte_q == PS2_BRK) begin
            brk_d = 1'b1;
         end else begin
            cv_d  = 1'b1;
            sc_d  = byte_q;
            ib_d  = brk_q;
            ie_d  = ext_q;
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end
   end

   // Jump key: repeats while held keep key_down high without extra pulses.
   always_comb begin
      kd_d = kd_q;
      jp_d = 1'b0;
      if (cv_q && (sc_q == JUMP_CODE) && !ie_q) begin
         if (ib_q) begin
            kd_d = 1'b0;
         end else begin
            kd_d = 1'b1;
            jp_d = ~kd_q;
         end
      end
   end

   assign key_if.scan_code   = sc_q;
   assign key_if.code_valid  = cv_q;
   assign key_if.is_break    = ib_q;
   assign key_if.is_extended = ie_q;
   assign key_if.frame_err   = err_q;
   assign key_if.key_down    = kd_q;
   assign key_if.jump_pulse  = jp_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: drives PS/2 frames into ps2_key_receiver and compares the
// key-event outputs against a byte-level model of the prefix/jump-key rules.
module tb_ps2_key_receiver;

   localparam int unsigned FL   = 8;
   localparam int unsigned TO   = 400;
   localparam int unsigned HALF = 30;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic KBclk = 1'b1;
   logic KBin  = 1'b1;

   ps2_key_receiver_if key_if ();

   ps2_key_receiver #(
      .FILTER_LEN     (FL),
      .TIMEOUT_CYCLES (TO),
      .JUMP_CODE      (8'h29)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .KBclk  (KBclk),
      .KBin   (KBin),
      .key_if (key_if)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor: counts strobe cycles; a strobe stuck high shows up as an overcount.
   int          cv_cnt = 0, fe_cnt = 0, jp_cnt = 0, jp_bad = 0;
   int unsigned fe_cyc = 0;
   always @(negedge clk) begin
      if (key_if.code_valid) cv_cnt++;
      if (key_if.frame_err) begin
         fe_cnt++;
         fe_cyc = cyc;
      end
      if (key_if.jump_pulse) begin
         jp_cnt++;
         if (!key_if.key_down) jp_bad++;
      end
   end

   // Reference model state
   int         exp_cv = 0, exp_fe = 0, exp_jp = 0;
   bit         m_ext = 0, m_brk = 0, m_key = 0;
   logic [7:0] exp_sc = 8'h00;
   bit         exp_brk = 0, exp_ext = 0;
   int unsigned last_fall = 0;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         exp_cv++;
         exp_sc  = b;
         exp_brk = m_brk;
         exp_ext = m_ext;
         if (b == 8'h29 && !m_ext) begin
            if (m_brk) m_key = 0;
            else begin
               if (!m_key) exp_jp++;
               m_key = 1;
            end
         end
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   task automatic model_reset();
      m_key = 0; m_ext = 0; m_brk = 0;
      exp_sc = 8'h00; exp_brk = 0; exp_ext = 0;
   endtask

   // nbits < 8 sends start plus that many data bits, then leaves the line idle.
   task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop_bit,
                             input int nbits);
      logic [10:0] bits;
      int          n;
      bits = {stop_bit, (~^b) ^ flip_par, b, 1'b0};
      n    = (nbits >= 8) ? 11 : nbits + 1;
      for (int i = 0; i < n; i++) begin
         KBin = bits[i];
         tick(HALF);
         KBclk     = 1'b0;
         last_fall = cyc;
         tick(HALF);
         KBclk = 1'b1;
      end
      KBin = 1'b1;
      tick(40);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(3);
      n_checks++;
      if ({key_if.scan_code, key_if.code_valid, key_if.is_break, key_if.is_extended,
           key_if.frame_err, key_if.key_down, key_if.jump_pulse} !== 14'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got sc=%h cv=%b ib=%b ie=%b fe=%b kd=%b jp=%b, want all 0",
                  key_if.scan_code, key_if.code_valid, key_if.is_break, key_if.is_extended,
                  key_if.frame_err, key_if.key_down, key_if.jump_pulse);
      end
      rst = 1'b1;
      tick(5);
   endtask

   task automatic test_make();
      send_frame(8'h29, 0, 1, 8);
      model_byte(8'h29);
      n_checks++;
      if ({cv_cnt, jp_cnt, fe_cnt} !== {exp_cv, exp_jp, exp_fe} || key_if.key_down !== m_key) begin
         n_fail++;
         $display("FAIL make_29: got cv=%0d jp=%0d fe=%0d kd=%b, want cv=%0d jp=%0d fe=%0d kd=%b",
                  cv_cnt, jp_cnt, fe_cnt, key_if.key_down, exp_cv, exp_jp, exp_fe, m_key);
      end
      n_checks++;
      if ({key_if.scan_code, key_if.is_break, key_if.is_extended} !== {exp_sc, exp_brk, exp_ext}) begin
         n_fail++;
         $display("FAIL make_29_fields: got sc=%h ib=%b ie=%b, want sc=%h ib=%b ie=%b",
                  key_if.scan_code, key_if.is_break, key_if.is_extended, exp_sc, exp_brk, exp_ext);
      end
      send_frame(8'h29, 0, 1, 8);
      model_byte(8'h29);
      n_checks++;
      if ({cv_cnt, jp_cnt} !== {exp_cv, exp_jp} || key_if.key_down !== m_key) begin
         n_fail++;
         $display("FAIL repeat_29: got cv=%0d jp=%0d kd=%b, want cv=%0d jp=%0d kd=%b",
                  cv_cnt, jp_cnt, key_if.key_down, exp_cv, exp_jp, m_key);
      end
   endtask

   task automatic test_break();
      send_frame(8'hF0, 0, 1, 8);
      model_byte(8'hF0);
      send_frame(8'h29, 0, 1, 8);
      model_byte(8'h29);
      n_checks++;
      if ({cv_cnt, jp_cnt, fe_cnt} !== {exp_cv, exp_jp, exp_fe} || key_if.key_down !== m_key ||
          {key_if.scan_code, key_if.is_break, key_if.is_extended} !== {exp_sc, exp_brk, exp_ext}) begin
         n_fail++;
         $display("FAIL break_29: got cv=%0d kd=%b sc=%h ib=%b ie=%b, want cv=%0d kd=%b sc=%h ib=%b ie=%b",
                  cv_cnt, key_if.key_down, key_if.scan_code, key_if.is_break, key_if.is_extended,
                  exp_cv, m_key, exp_sc, exp_brk, exp_ext);
      end
   endtask

   task automatic test_extended();
      send_frame(8'hE0, 0, 1, 8);
      model_byte(8'hE0);
      send_frame(8'h29, 0, 1, 8);
      model_byte(8'h29);
      n_checks++;
      if (cv_cnt !== exp_cv || key_if.key_down !== m_key || jp_cnt !== exp_jp ||
          {key_if.scan_code, key_if.is_break, key_if.is_extended} !== {exp_sc, exp_brk, exp_ext}) begin
         n_fail++;
         $display("FAIL ext_29: got cv=%0d kd=%b jp=%0d sc=%h ie=%b, want cv=%0d kd=%b jp=%0d sc=%h ie=%b",
                  cv_cnt, key_if.key_down, jp_cnt, key_if.scan_code, key_if.is_extended,
                  exp_cv, m_key, exp_jp, exp_sc, exp_ext);
      end
      send_frame(8'h1C, 0, 1, 8);
      model_byte(8'h1C);
      n_checks++;
      if (cv_cnt !== exp_cv ||
          {key_if.scan_code, key_if.is_break, key_if.is_extended} !== {exp_sc, exp_brk, exp_ext}) begin
         n_fail++;
         $display("FAIL plain_1c: got cv=%0d sc=%h ie=%b, want cv=%0d sc=%h ie=%b",
                  cv_cnt, key_if.scan_code, key_if.is_extended, exp_cv, exp_sc, exp_ext);
      end
   endtask

   task automatic test_frame_err();
      send_frame(8'h29, 1, 1, 8);
      exp_fe++;
      n_checks++;
      if ({fe_cnt, cv_cnt} !== {exp_fe, exp_cv}) begin
         n_fail++;
         $display("FAIL parity_err: got fe=%0d cv=%0d, want fe=%0d cv=%0d",
                  fe_cnt, cv_cnt, exp_fe, exp_cv);
      end
      send_frame(8'h29, 0, 0, 8);
      exp_fe++;
      n_checks++;
      if ({fe_cnt, cv_cnt} !== {exp_fe, exp_cv}) begin
         n_fail++;
         $display("FAIL stop_err: got fe=%0d cv=%0d, want fe=%0d cv=%0d",
                  fe_cnt, cv_cnt, exp_fe, exp_cv);
      end
      send_frame(8'h1C, 0, 1, 8);
      model_byte(8'h1C);
      n_checks++;
      if (cv_cnt !== exp_cv || key_if.scan_code !== exp_sc) begin
         n_fail++;
         $display("FAIL after_err_1c: got cv=%0d sc=%h, want cv=%0d sc=%h",
                  cv_cnt, key_if.scan_code, exp_cv, exp_sc);
      end
   endtask

   task automatic test_timeout();
      int unsigned lat;
      send_frame(8'hE0, 0, 1, 8);
      model_byte(8'hE0);
      send_frame(8'h55, 0, 1, 5);
      for (int i = 0; i < int'(TO) + 100 && fe_cnt == exp_fe; i++) tick(1);
      exp_fe++;
      m_ext = 0;
      m_brk = 0;
      lat = fe_cyc - last_fall;
      n_checks++;
      if (fe_cnt !== exp_fe) begin
         n_fail++;
         $display("FAIL timeout_fired: got fe=%0d, want fe=%0d", fe_cnt, exp_fe);
      end
      // Latency from the driven KBclk fall: TIMEOUT plus sync/filter/edge delay.
      n_checks++;
      if (lat < TO + FL || lat > TO + FL + 6) begin
         n_fail++;
         $display("FAIL timeout_latency: got %0d cycles, want %0d..%0d", lat, TO + FL, TO + FL + 6);
      end
      send_frame(8'h1C, 0, 1, 8);
      model_byte(8'h1C);
      n_checks++;
      if (cv_cnt !== exp_cv || fe_cnt !== exp_fe ||
          {key_if.scan_code, key_if.is_extended} !== {exp_sc, exp_ext}) begin
         n_fail++;
         $display("FAIL after_timeout_1c: got cv=%0d fe=%0d sc=%h ie=%b, want cv=%0d fe=%0d sc=%h ie=%b",
                  cv_cnt, fe_cnt, key_if.scan_code, key_if.is_extended,
                  exp_cv, exp_fe, exp_sc, exp_ext);
      end
   endtask

   task automatic test_glitch();
      // Data low during the glitch: a glitch that got through would start a frame
      // that then times out.
      KBin  = 1'b0;
      KBclk = 1'b0;
      tick(FL - 2);
      KBclk = 1'b1;
      tick(5);
      KBin = 1'b1;
      tick(TO + 50);
      n_checks++;
      if ({fe_cnt, cv_cnt} !== {exp_fe, exp_cv}) begin
         n_fail++;
         $display("FAIL glitch_ignored: got fe=%0d cv=%0d, want fe=%0d cv=%0d",
                  fe_cnt, cv_cnt, exp_fe, exp_cv);
      end
      send_frame(8'h5A, 0, 1, 8);
      model_byte(8'h5A);
      n_checks++;
      if (cv_cnt !== exp_cv || key_if.scan_code !== exp_sc) begin
         n_fail++;
         $display("FAIL after_glitch_5a: got cv=%0d sc=%h, want cv=%0d sc=%h",
                  cv_cnt, key_if.scan_code, exp_cv, exp_sc);
      end
   endtask

   task automatic test_reset_mid();
      send_frame(8'h29, 0, 1, 8);
      model_byte(8'h29);
      send_frame(8'hA5, 0, 1, 3);
      rst = 1'b0;
      tick(2);
      model_reset();
      n_checks++;
      if ({key_if.scan_code, key_if.code_valid, key_if.is_break, key_if.is_extended,
           key_if.frame_err, key_if.key_down, key_if.jump_pulse} !== 14'b0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got sc=%h cv=%b ib=%b ie=%b fe=%b kd=%b jp=%b, want all 0",
                  key_if.scan_code, key_if.code_valid, key_if.is_break, key_if.is_extended,
                  key_if.frame_err, key_if.key_down, key_if.jump_pulse);
      end
      rst = 1'b1;
      tick(10);
      send_frame(8'h1C, 0, 1, 8);
      model_byte(8'h1C);
      n_checks++;
      if ({cv_cnt, fe_cnt} !== {exp_cv, exp_fe} || key_if.key_down !== m_key ||
          {key_if.scan_code, key_if.is_break, key_if.is_extended} !== {exp_sc, exp_brk, exp_ext}) begin
         n_fail++;
         $display("FAIL after_reset_1c: got cv=%0d fe=%0d kd=%b sc=%h, want cv=%0d fe=%0d kd=%b sc=%h",
                  cv_cnt, fe_cnt, key_if.key_down, key_if.scan_code, exp_cv, exp_fe, m_key, exp_sc);
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      bit         bad;
      for (int i = 0; i < 14; i++) begin
         case ($urandom_range(0, 5))
            0:       b = 8'hE0;
            1:       b = 8'hF0;
            2, 3:    b = 8'h29;
            default: b = 8'($urandom_range(0, 255));
         endcase
         bad = ($urandom_range(0, 7) == 0);
         send_frame(b, bad, 1, 8);
         if (bad) exp_fe++;
         else model_byte(b);
         n_checks++;
         if ({cv_cnt, fe_cnt, jp_cnt} !== {exp_cv, exp_fe, exp_jp} || key_if.key_down !== m_key ||
             {key_if.scan_code, key_if.is_break, key_if.is_extended} !== {exp_sc, exp_brk, exp_ext}) begin
            n_fail++;
            $display("FAIL random_%0d byte=%h bad=%b: got cv=%0d fe=%0d jp=%0d kd=%b sc=%h ib=%b ie=%b, want cv=%0d fe=%0d jp=%0d kd=%b sc=%h ib=%b ie=%b",
                     i, b, bad, cv_cnt, fe_cnt, jp_cnt, key_if.key_down, key_if.scan_code,
                     key_if.is_break, key_if.is_extended, exp_cv, exp_fe, exp_jp, m_key,
                     exp_sc, exp_brk, exp_ext);
         end
      end
   endtask

   initial begin
      test_reset();
      test_make();
      test_break();
      test_extended();
      test_frame_err();
      test_timeout();
      test_glitch();
      test_reset_mid();
      test_random();
      n_checks++;
      if (jp_bad !== 0) begin
         n_fail++;
         $display("FAIL jump_pulse_align: got %0d pulses without key_down, want 0", jp_bad);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_key_receiver.md
Name: ps2_key_receiver

Overview:
Upstream input stage for the game's control unit. It receives the raw PS/2 keyboard lines KBclk/KBin and removes metastability and glitches. It deframes 11-bit PS/2 frames and decodes make, break and extended scan-code sequences. It presents clean, clk-domain key events plus a jump-key level and pulse, which the control unit consumes for dino jump control.

Parameters:
FILTER_LEN, 8, consecutive equal clk samples required before the filtered KBclk changes state
TIMEOUT_CYCLES, 50000, clk cycles without a KBclk falling edge mid-frame before the frame is aborted (1 ms at 50 MHz)
JUMP_CODE, 8'h29, non-extended scan code treated as the jump key (space bar)

Ports:
clk  input  1  system/pixel clock; all logic on posedge
rst  input  1  asynchronous, active-low reset
KBclk  input  1  raw PS/2 clock, asynchronous
KBin  input  1  raw PS/2 data, asynchronous
scan_code  output  8  last decoded non-prefix scan code
code_valid  output  1  one-cycle strobe: scan_code, is_break and is_extended are valid
is_break  output  1  scan code was preceded by F0
is_extended  output  1  scan code was preceded by E0
frame_err  output  1  one-cycle strobe: parity error, bad stop bit or timeout
key_down  output  1  level: JUMP_CODE currently held
jump_pulse  output  1  one-cycle strobe on the key_down 0->1 transition

Behaviour:
- Reset: clk is the only clock. rst is asynchronous and active-low. All outputs are 0, FSM is IDLE, prefix flags are clear, filter output is 1, and sync flops are 1 (idle line level).
- Sync: KBclk and KBin each pass through 2 flops.
- Filter: a counter tracks the synced KBclk. The filtered clock takes the new level only after FILTER_LEN consecutive equal samples. A shorter glitch is ignored.
- Edge detect: fall is asserted for exactly one cycle when the registered filtered clock goes 1->0. Synced KBin is sampled in that cycle.
- FSM (advances only on fall, except timeout):
  - IDLE: if data=0 (start bit), go to DATA with bit count 0. If data=1, stay in IDLE and raise no error.
  - DATA: shift bits in LSB first. After the 8th bit, go to PARITY.
  - PARITY: store the bit, then go to STOP.
  - STOP: always return to IDLE. The byte is good only if data=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). Otherwise frame_err pulses.
- Timeout: in DATA, PARITY or STOP, a cycle counter clears on each fall. When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE, frame_err pulses, and the prefix flags clear.
- Byte latency: a good byte is handed to the decoder in the cycle after the stop-bit fall. Decoder outputs are registered, so code_valid rises 2 cycles after the stop-bit fall.
- Decoder, per good byte:
  - E0: set ext_pend. No strobe.
  - F0: set brk_pend. No strobe.
  - Any other byte: for 1 cycle, drive code_valid=1, scan_code=byte, is_break=brk_pend, is_extended=ext_pend. Both pending flags clear in the same cycle.
  - scan_code, is_break and is_extended hold their values until the next strobe.
- Jump key: applies on code_valid when scan_code==JUMP_CODE and is_extended=0.
  - Make: key_down<=1. jump_pulse pulses, in the same cycle as key_down rising, only if key_down was 0.
  - Break: key_down<=0.
  - Typematic repeat makes keep key_down=1 and produce no further jump_pulse.
  - An extended 0x29 (E0 29) does not affect key_down.
- Simultaneous events: a timeout and a fall cannot coincide, because fall resets the counter and is evaluated first.
- frame_err does not clear key_down.
- Reset mid-frame: an rst assertion discards the partial frame immediately.

Decomposition:
- Package ps2_pkg holds:
  - FSM state encoding (IDLE, DATA, PARITY, STOP);
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_SPACE=8'h29.
- Sub-module ps2_sync_filter holds the 2-flop synchronizers, the FILTER_LEN glitch filter and the falling-edge detector. Its outputs are fall and data.
- The deframer FSM, timeout counter and decoder stay in ps2_key_receiver.

Test Plan:
- Frame 0x29, odd parity (parity bit 0), KBclk period 80 us -> code_valid 1 cycle, scan_code=8'h29, is_break=0, key_down=1, jump_pulse exactly 1 cycle; a second 0x29 gives no further jump_pulse.
- Frames F0 then 29 -> one code_valid only, scan_code=8'h29, is_break=1, key_down falls to 0.
- Frames E0 29 -> code_valid with is_extended=1, key_down unchanged. Then send 0x1C -> is_extended=0.
- Frame 0x29 with parity flipped, and a separate frame with stop=0 -> frame_err 1 cycle each, no code_valid; the following good frame 0x1C decodes normally.
- Stop after 5 data bits -> frame_err exactly TIMEOUT_CYCLES cycles after the last fall, FSM back in IDLE; the next full frame decodes.
- KBclk glitch low for FILTER_LEN-2 cycles during idle -> no state change. Assert rst mid-frame -> all outputs 0; the next clean frame decodes.
